maxpool_stream_ctrl: RTL

MAXPOOL_STREAM_CTRL -- requirements
Module: maxpool_stream_ctrl

---
 rtl/maxpool_stream_ctrl_if.sv | 53 +++++
 rtl/maxpool_stream_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_ctrl_if.sv
// maxpool_stream_ctrl_if
// Purpose: groups the controller's frame-control, upstream pixel stream,
//          pooling-layer and result-buffer signals into one bundle.
// Signals:
//   start       frame-start request (sampled only while idle)
//   in_valid    upstream pixel valid
//   in_pixels   8 binary pixels, bit i = channel i+1
//   in_ready    controller accepts an upstream pixel this cycle
//   pool_rst_n  active-low reset to the pooling layer
//   pool_pixels pixels driven to pixel_in_1..8 of the pooling layer
//   pool_valid  valid_out_maxpool from the pooling layer
//   pool_out    maxpool_out_1..8 from the pooling layer
//   out_we      result-buffer write enable
//   out_addr    result-buffer address (row-major pooled position)
//   out_data    result word
//   busy        controller is not idle
//   done        one-cycle frame-complete pulse
//   err         sticky error flag
// Modports: master = controller side, slave = environment side.
interface maxpool_stream_ctrl_if #(
  parameter int WIDTH  = 26,
  parameter int HEIGHT = 26
);
  localparam int RES_TOTAL = (WIDTH / 2) * (HEIGHT / 2);
  localparam int AW        = (RES_TOTAL > 1) ? $clog2(RES_TOTAL) : 1;

  logic          start;
  logic          in_valid;
  logic [7:0]    in_pixels;
  logic          in_ready;
  logic          pool_rst_n;
  logic [7:0]    pool_pixels;
  logic          pool_valid;
  logic [7:0]    pool_out;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, in_valid, in_pixels, pool_valid, pool_out,
    output in_ready, pool_rst_n, pool_pixels, out_we, out_addr, out_data,
           busy, done, err
  );

  modport slave (
    output start, in_valid, in_pixels, pool_valid, pool_out,
    input  in_ready, pool_rst_n, pool_pixels, out_we, out_addr, out_data,
           busy, done, err
  );
endinterface

// File: rtl/maxpool_stream_ctrl.sv
// maxpool_stream_ctrl
// Purpose: sequences one feature-map frame through a non-stallable max-pool
//          layer: resets the layer, streams WIDTH*HEIGHT pixels into it,
//          collects (WIDTH/2)*(HEIGHT/2) pooled results into a buffer in
//          row-major order, and flags stalls, surplus results and drain
//          timeouts on a sticky err.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   maxpool_stream_ctrl_if.master (stream, pool-layer, buffer, status)
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start, pool layer held in reset
//   S_FLUSH | one cycle of pool-layer reset after start
//   S_FEED  | accepting pixels and forwarding them to the pool layer
//   S_DRAIN | all pixels sent, waiting (bounded) for the remaining results
//   S_FIN   | one-cycle done pulse, pool layer back in reset
module maxpool_stream_ctrl #(
  parameter int WIDTH     = 26,
  parameter int HEIGHT    = 26,
  parameter int DRAIN_MAX = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool_stream_ctrl_if.master bus
);
  localparam int PIX_TOTAL = WIDTH * HEIGHT;
  localparam int RES_TOTAL = (WIDTH / 2) * (HEIGHT / 2);
  localparam int AW        = (RES_TOTAL > 1) ? $clog2(RES_TOTAL) : 1;
  localparam int PCW       = $clog2(PIX_TOTAL + 1);
  localparam int RCW       = $clog2(RES_TOTAL + 1);
  localparam int DCW       = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_FEED, S_DRAIN, S_FIN} state_t;

  state_t         r_state;
  logic [PCW-1:0] r_pix_cnt;
  logic [RCW-1:0] r_res_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_in_ready;
  logic           r_pool_rst_n;
  logic [7:0]     r_pool_pixels;
  logic           r_out_we;
  logic [AW-1:0]  r_out_addr;
  logic [7:0]     r_out_data;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic w_accept, w_pix_last, w_stall;
  logic w_res_active, w_res_take, w_res_over, w_res_last;

  assign w_accept   = (r_state == S_FEED) && r_in_ready && bus.in_valid;
  assign w_pix_last = w_accept && (r_pix_cnt == PCW'(PIX_TOTAL - 1));
  // The pool layer has no backpressure, so a gap after the first pixel
  // corrupts its window state; a gap before the first pixel is harmless.
  assign w_stall    = (r_state == S_FEED) && r_in_ready && !bus.in_valid &&
                      (r_pix_cnt != '0);

  assign w_res_active = bus.pool_valid &&
                        ((r_state == S_FEED) || (r_state == S_DRAIN) || (r_state == S_FIN));
  assign w_res_take   = w_res_active && (r_res_cnt != RCW'(RES_TOTAL));
  assign w_res_over   = w_res_active && (r_res_cnt == RCW'(RES_TOTAL));
  assign w_res_last   = w_res_take && (r_res_cnt == RCW'(RES_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pix_cnt     <= '0;
      r_res_cnt     <= '0;
      r_drain_cnt   <= '0;
      r_in_ready    <= 1'b0;
      r_pool_rst_n  <= 1'b0;
      r_pool_pixels <= '0;
      r_out_we      <= 1'b0;
      r_out_addr    <= '0;
      r_out_data    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_out_we      <= 1'b0;
      r_done        <= 1'b0;
      r_pool_pixels <= '0;

      // Result capture runs alongside the pixel stream so a last pixel and a
      // result arriving together are both honoured.
      if (w_res_take) begin
        r_out_we   <= 1'b1;
        r_out_data <= bus.pool_out;
        r_out_addr <= r_res_cnt[AW-1:0];
        r_res_cnt  <= r_res_cnt + RCW'(1);
      end
      if (w_res_over) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_FLUSH;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_pix_cnt   <= '0;
            r_res_cnt   <= '0;
            r_drain_cnt <= '0;
          end
        end
        S_FLUSH: begin
          r_state      <= S_FEED;
          r_pool_rst_n <= 1'b1;
          r_in_ready   <= 1'b1;
        end
        S_FEED: begin
          if (w_accept) begin
            r_pool_pixels <= bus.in_pixels;
            r_pix_cnt     <= r_pix_cnt + PCW'(1);
          end
          if (w_res_last) begin
            r_state      <= S_FIN;
            r_in_ready   <= 1'b0;
            r_pool_rst_n <= 1'b0;
            r_done       <= 1'b1;
          end else if (w_pix_last) begin
            r_state     <= S_DRAIN;
            r_in_ready  <= 1'b0;
            r_drain_cnt <= DCW'(DRAIN_MAX - 1);
          end else if (w_stall) begin
            r_err        <= 1'b1;
            r_state      <= S_FIN;
            r_in_ready   <= 1'b0;
            r_pool_rst_n <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_res_last || (r_drain_cnt == '0)) begin
            if (!w_res_last) r_err <= 1'b1;
            r_state      <= S_FIN;
            r_pool_rst_n <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.pool_rst_n  = r_pool_rst_n;
  assign bus.pool_pixels = r_pool_pixels;
  assign bus.out_we      = r_out_we;
  assign bus.out_addr    = r_out_addr;
  assign bus.out_data    = r_out_data;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule
